// File: rtl/counter_bank.sv
// counter_bank: NCH independent up/down event counters sharing one terminal value.
//
// Parameters
//   WL  - counter width per channel (>= 2)
//   NCH - number of channels (>= 1)
//   SAT - 0: wrap at the terminal value, 1: saturate there (all channels)
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset of every channel
//   cnt_en   in   per-channel count enable (level, one step per enabled cycle)
//   cnt_rst  in   per-channel synchronous clear of the count
//   cnt_dn   in   per-channel direction, 0 = up, 1 = down
//   ld_en    in   per-channel parallel load strobe
//   ld_val   in   load values, channel i at [i*WL +: WL]
//   max_val  in   shared terminal value, count range 0..max_val
//   ovf_clr  in   per-channel sticky overflow clear
//   cnt      out  registered counts, channel i at [i*WL +: WL]
//   tc       out  registered terminal-count pulse
//   ovf      out  sticky overflow/underflow flags
//   any_ovf  out  OR of all ovf bits
module counter_bank #(
    parameter int unsigned WL  = 16,
    parameter int unsigned NCH = 4,
    parameter int unsigned SAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      cnt_en,
    input  logic [NCH-1:0]      cnt_rst,
    input  logic [NCH-1:0]      cnt_dn,
    input  logic [NCH-1:0]      ld_en,
    input  logic [NCH*WL-1:0]   ld_val,
    input  logic [WL-1:0]       max_val,
    input  logic [NCH-1:0]      ovf_clr,
    output logic [NCH*WL-1:0]   cnt,
    output logic [NCH-1:0]      tc,
    output logic [NCH-1:0]      ovf,
    output logic                any_ovf
);

    localparam bit Saturate = (SAT != 0);

    logic [NCH*WL-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]    tc_q, tc_d;
    logic [NCH-1:0]    ovf_q, ovf_d;

    logic [WL-1:0] cur;
    logic [WL-1:0] nxt;
    logic [WL-1:0] ld_c;
    logic          term;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = '0;
        ovf_d = ovf_q;
        cur   = '0;
        nxt   = '0;
        ld_c  = '0;
        term  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cur  = cnt_q[i*WL +: WL];
            ld_c = ld_val[i*WL +: WL];
            nxt  = cur;
            term = 1'b0;
            if (cnt_rst[i]) begin
                nxt = '0;
            end else if (ld_en[i]) begin
                // Loads are clamped into range and never raise an event.
                nxt = (ld_c > max_val) ? max_val : ld_c;
            end else if (cnt_en[i]) begin
                if (!cnt_dn[i]) begin
                    // cur may exceed max_val after max_val was lowered; that is terminal too.
                    if (cur >= max_val) begin
                        term = 1'b1;
                        nxt  = Saturate ? max_val : '0;
                    end else begin
                        nxt = cur + WL'(1);
                    end
                end else begin
                    // Above max_val a down count just steps toward the range.
                    if (cur == '0) begin
                        term = 1'b1;
                        nxt  = Saturate ? '0 : max_val;
                    end else begin
                        nxt = cur - WL'(1);
                    end
                end
            end
            cnt_d[i*WL +: WL] = nxt;
            tc_d[i]           = term;
            // A new event wins over a simultaneous clear.
            if (term) begin
                ovf_d[i] = 1'b1;
            end else if (ovf_clr[i]) begin
                ovf_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign any_ovf = |ovf_q;

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

    localparam int WL  = 4;
    localparam int NCH = 2;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    cnt_en;
    logic [NCH-1:0]    cnt_rst;
    logic [NCH-1:0]    cnt_dn;
    logic [NCH-1:0]    ld_en;
    logic [NCH*WL-1:0] ld_val;
    logic [WL-1:0]     max_val;
    logic [NCH-1:0]    ovf_clr;

    logic [NCH*WL-1:0] cnt_w, cnt_s;
    logic [NCH-1:0]    tc_w, tc_s, ovf_w, ovf_s;
    logic              any_w, any_s;

    int vectors;
    int miscompares;

    // Reference state: index 0 = wrap instance, 1 = saturate instance.
    int m_cnt [2][NCH];
    int m_tc  [2][NCH];
    int m_ovf [2][NCH];

    counter_bank #(.WL(WL), .NCH(NCH), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .cnt_rst(cnt_rst), .cnt_dn(cnt_dn),
        .ld_en(ld_en), .ld_val(ld_val), .max_val(max_val), .ovf_clr(ovf_clr),
        .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w), .any_ovf(any_w)
    );

    counter_bank #(.WL(WL), .NCH(NCH), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .cnt_rst(cnt_rst), .cnt_dn(cnt_dn),
        .ld_en(ld_en), .ld_val(ld_val), .max_val(max_val), .ovf_clr(ovf_clr),
        .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s), .any_ovf(any_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model from the current inputs using plain integer rules.
    task automatic model_step();
        for (int s = 0; s < 2; s++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                int c, m, ld, ev;
                c  = m_cnt[s][ch];
                m  = int'(max_val);
                ld = int'(ld_val[ch*WL +: WL]);
                ev = 0;
                if (rst) begin
                    c = 0;
                    m_ovf[s][ch] = 0;
                end else begin
                    if (cnt_rst[ch]) c = 0;
                    else if (ld_en[ch]) c = (ld < m) ? ld : m;
                    else if (cnt_en[ch]) begin
                        if (!cnt_dn[ch]) begin
                            if (c + 1 > m) begin ev = 1; c = (s == 1) ? m : 0; end
                            else c = c + 1;
                        end else begin
                            if (c - 1 < 0) begin ev = 1; c = (s == 1) ? 0 : m; end
                            else c = c - 1;
                        end
                    end
                    if (ev != 0) m_ovf[s][ch] = 1;
                    else if (ovf_clr[ch]) m_ovf[s][ch] = 0;
                end
                m_cnt[s][ch] = c;
                m_tc[s][ch]  = ev;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; cnt_en = '0; cnt_rst = '0; cnt_dn = '0;
        ld_en = '0; ld_val = '0; ovf_clr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        max_val = 4'd9;
        rst = 1'b1;
        cnt_en = 2'b11;
        repeat (3) tick();
        vectors++;
        if (cnt_w !== 8'h00 || cnt_s !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_cnt: wrap=%h sat=%h required 00", cnt_w, cnt_s);
        end
        vectors++;
        if (tc_w !== 2'b00 || ovf_w !== 2'b00 || tc_s !== 2'b00 || ovf_s !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: tc=%b/%b ovf=%b/%b required 00", tc_w, tc_s, ovf_w, ovf_s);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (cnt_w !== 8'h11 || cnt_s !== 8'h11) begin
            miscompares++;
            $display("FAIL reset_release: wrap=%h sat=%h required 11", cnt_w, cnt_s);
        end
    endtask

    task automatic test_wrap_up();
        do_reset();
        max_val = 4'd9;
        cnt_en = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] e;
            e = 4'(k % 10);
            tick();
            vectors++;
            if (cnt_w[3:0] !== e || tc_w[0] !== (e == 4'd0) || ovf_w[0] !== (k >= 10)) begin
                miscompares++;
                $display("FAIL wrap_up step %0d: cnt=%0d tc=%b ovf=%b required cnt=%0d tc=%b ovf=%b",
                         k, cnt_w[3:0], tc_w[0], ovf_w[0], e, (e == 4'd0), (k >= 10));
            end
        end
    endtask

    task automatic test_wrap_down_sat();
        do_reset();
        max_val = 4'd9;
        cnt_en = 2'b10;
        cnt_dn = 2'b10;
        tick();
        vectors++;
        if (cnt_w[7:4] !== 4'd9 || tc_w !== 2'b10 || ovf_w !== 2'b10) begin
            miscompares++;
            $display("FAIL wrap_down: cnt1=%0d tc=%b ovf=%b required 9 10 10",
                     cnt_w[7:4], tc_w, ovf_w);
        end
        vectors++;
        if (cnt_s[7:4] !== 4'd0 || tc_s !== 2'b10) begin
            miscompares++;
            $display("FAIL sat_down: cnt1=%0d tc=%b required 0 10", cnt_s[7:4], tc_s);
        end
        idle_inputs();
        ld_en = 2'b01;
        ld_val = 8'h08;
        tick();
        idle_inputs();
        cnt_en = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (cnt_s[3:0] !== 4'd9 || tc_s[0] !== (k != 0)) begin
                miscompares++;
                $display("FAIL sat_up step %0d: cnt=%0d tc=%b required 9 %b",
                         k, cnt_s[3:0], tc_s[0], (k != 0));
            end
        end
    endtask

    task automatic test_priority();
        do_reset();
        max_val = 4'd9;
        cnt_en = 2'b01; cnt_rst = 2'b01; ld_en = 2'b01; ld_val = 8'h05;
        tick();
        vectors++;
        if (cnt_w[3:0] !== 4'd0) begin
            miscompares++;
            $display("FAIL priority_rst: cnt=%0d required 0", cnt_w[3:0]);
        end
        idle_inputs();
        ld_en = 2'b01; ld_val = 8'h0C; cnt_en = 2'b01;
        tick();
        vectors++;
        if (cnt_w[3:0] !== 4'd9 || tc_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL priority_ld_clamp: cnt=%0d tc=%b required 9 0", cnt_w[3:0], tc_w[0]);
        end
    endtask

    task automatic test_dynamic_max();
        do_reset();
        max_val = 4'd9;
        ld_en = 2'b01; ld_val = 8'h08;
        tick();
        idle_inputs();
        max_val = 4'd3;
        cnt_en = 2'b01;
        tick();
        vectors++;
        if (cnt_w[3:0] !== 4'd0 || tc_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL dyn_max_up: cnt=%0d tc=%b required 0 1", cnt_w[3:0], tc_w[0]);
        end
        idle_inputs();
        max_val = 4'd9;
        ld_en = 2'b01; ld_val = 8'h07;
        tick();
        idle_inputs();
        max_val = 4'd3;
        cnt_en = 2'b01; cnt_dn = 2'b01;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            e = 4'(6 - k);
            tick();
            vectors++;
            if (cnt_w[3:0] !== e || tc_w[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL dyn_max_down step %0d: cnt=%0d tc=%b required %0d 0",
                         k, cnt_w[3:0], tc_w[0], e);
            end
        end
    endtask

    task automatic test_ovf_clear();
        do_reset();
        max_val = 4'd9;
        ld_en = 2'b01; ld_val = 8'h09;
        tick();
        idle_inputs();
        cnt_en = 2'b01; ovf_clr = 2'b01;
        tick();
        vectors++;
        if (cnt_w[3:0] !== 4'd0 || tc_w[0] !== 1'b1 || ovf_w[0] !== 1'b1 || any_w !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_race: cnt=%0d tc=%b ovf=%b any=%b required 0 1 1 1",
                     cnt_w[3:0], tc_w[0], ovf_w[0], any_w);
        end
        idle_inputs();
        ovf_clr = 2'b01;
        tick();
        vectors++;
        if (ovf_w !== 2'b00 || any_w !== 1'b0 || tc_w !== 2'b00) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b any=%b tc=%b required 00 0 00", ovf_w, any_w, tc_w);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            cnt_en  = NCH'($urandom);
            cnt_dn  = NCH'($urandom);
            cnt_rst = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            ld_en   = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            ld_val  = (NCH*WL)'($urandom);
            ovf_clr = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            if ($urandom_range(0, 19) == 0) max_val = WL'($urandom);
            tick();
            for (int s = 0; s < 2; s++) begin
                logic [NCH*WL-1:0] ec, ac;
                logic [NCH-1:0]    et, eo, at, ao;
                logic              aa;
                for (int ch = 0; ch < NCH; ch++) begin
                    ec[ch*WL +: WL] = WL'(m_cnt[s][ch]);
                    et[ch] = (m_tc[s][ch] != 0);
                    eo[ch] = (m_ovf[s][ch] != 0);
                end
                ac = (s == 0) ? cnt_w : cnt_s;
                at = (s == 0) ? tc_w : tc_s;
                ao = (s == 0) ? ovf_w : ovf_s;
                aa = (s == 0) ? any_w : any_s;
                vectors++;
                if (ac !== ec || at !== et || ao !== eo || aa !== (|eo)) begin
                    miscompares++;
                    $display("FAIL random cyc %0d sat=%0d: cnt=%h tc=%b ovf=%b any=%b required %h %b %b %b",
                             n, s, ac, at, ao, aa, ec, et, eo, (|eo));
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        max_val = 4'd9;
        idle_inputs();
        test_reset();
        test_wrap_up();
        test_wrap_down_sat();
        test_priority();
        test_dynamic_max();
        test_ovf_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
